// File: rtl/trng_pkg.sv
// Shared types for the TRNG word arbiter: word width and the controller state encoding.
package trng_pkg;

  localparam int unsigned RND_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StActive,
    StFlush,
    StFault
  } trng_state_e;

endpackage

// File: rtl/trng_arb_fifo.sv
// Word buffer for trng_arb: synchronous write and pop, with a flush that zeroes every entry.
module trng_arb_fifo
  import trng_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned LW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             wr_en_i,
  input  logic [RND_W-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [RND_W-1:0] rd_data_o,
  output logic [LW-1:0]    level_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [RND_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    cnt_q, cnt_d;
  logic             wr_ok, rd_ok;

  assign full_o    = (cnt_q == LW'(DEPTH));
  assign empty_o   = (cnt_q == '0);
  assign wr_ok     = wr_en_i & ~full_o;
  assign rd_ok     = rd_en_i & ~empty_o;
  assign rd_data_o = mem_q[rptr_q];
  assign level_o   = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    unique case ({wr_ok, rd_ok})
      2'b10:   cnt_d = cnt_q + LW'(1);
      2'b01:   cnt_d = cnt_q - LW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_ok) begin
        mem_q[wptr_q] <= wr_data_i;
        wptr_q        <= wptr_q + AW'(1);
      end
      if (rd_ok) begin
        rptr_q <= rptr_q + AW'(1);
      end
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/trng_arb.sv
// Buffers TRNG words and hands them out round-robin to requesters; sticky fault on total failure.
// Optional served-word counter enabled by defining TRNG_ARB_WORD_CNT_EN.
module trng_arb
  import trng_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DEPTH   = 4,
  localparam int unsigned LW = $clog2(DEPTH) + 1,
  localparam int unsigned PW = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               rnd_ready_i,
  input  logic [RND_W-1:0]   rnd_data_i,
  input  logic               error_i,
  input  logic               total_failure_i,
  output logic               ack_read_o,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [RND_W-1:0]   rnd_data_o,
  output logic [LW-1:0]      level_o,
  output logic               fault_o
`ifdef TRNG_ARB_WORD_CNT_EN
  ,
  output logic [15:0]        served_cnt_o
`endif
);

  trng_state_e        state_q;
  logic [PW-1:0]      ptr_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [RND_W-1:0]   data_q;
  logic               ack_q;
  logic               fault_q;

  logic               live;
  logic [NUM_REQ-1:0] elig;
  logic               win_found;
  logic [PW-1:0]      win_idx;
  logic [PW-1:0]      cand;
  logic [PW-1:0]      ptr_nxt;
  logic [NUM_REQ-1:0] gnt_onehot;
  logic               cap_en, pop_en, flush_en, nonempty_nxt;

  logic [RND_W-1:0]   fifo_head;
  logic [LW-1:0]      fifo_level;
  logic               fifo_full, fifo_empty;

  assign live = (state_q == StIdle) || (state_q == StActive);
  // A requester holding its level through its grant cycle must not win again immediately.
  assign elig = req_i & ~gnt_q;

  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = PW'((32'(ptr_q) + i) % NUM_REQ);
      if (!win_found && elig[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  assign ptr_nxt    = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
  assign gnt_onehot = NUM_REQ'(1) << win_idx;

  // Full/empty are start-of-cycle views; failure and error outrank capture and grant.
  assign cap_en = live & rnd_ready_i & ~fifo_full & ~ack_q & ~error_i & ~total_failure_i;
  assign pop_en = live & ~fifo_empty & win_found & ~error_i & ~total_failure_i;
  assign flush_en = total_failure_i | (live & error_i) | (state_q == StFault);
  assign nonempty_nxt = cap_en || (fifo_level != LW'(pop_en));

  trng_arb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .flush_i   (flush_en),
    .wr_en_i   (cap_en),
    .wr_data_i (rnd_data_i),
    .rd_en_i   (pop_en),
    .rd_data_o (fifo_head),
    .level_o   (fifo_level),
    .full_o    (fifo_full),
    .empty_o   (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
      fault_q <= 1'b0;
    end else if (total_failure_i) begin
      state_q <= StFault;
      fault_q <= 1'b1;
      gnt_q   <= '0;
      data_q  <= '0;
      ack_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StActive: begin
          if (error_i) begin
            state_q <= StFlush;
            gnt_q   <= '0;
            data_q  <= '0;
            ack_q   <= 1'b0;
          end else begin
            ack_q   <= cap_en;
            gnt_q   <= pop_en ? gnt_onehot : '0;
            data_q  <= pop_en ? fifo_head : '0;
            state_q <= nonempty_nxt ? StActive : StIdle;
            if (pop_en) begin
              ptr_q <= ptr_nxt;
            end
          end
        end
        StFlush: begin
          state_q <= StIdle;
          gnt_q   <= '0;
          data_q  <= '0;
          ack_q   <= 1'b0;
        end
        default: begin
          gnt_q  <= '0;
          data_q <= '0;
          ack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign ack_read_o = ack_q;
  assign gnt_o      = gnt_q;
  assign rnd_data_o = data_q;
  assign level_o    = fifo_level;
  assign fault_o    = fault_q;

`ifdef TRNG_ARB_WORD_CNT_EN
  logic [15:0] served_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      served_cnt_q <= '0;
    end else if (pop_en && (served_cnt_q != 16'hFFFF)) begin
      served_cnt_q <= served_cnt_q + 16'd1;
    end
  end

  assign served_cnt_o = served_cnt_q;
`endif

endmodule
